core_lsu_bus_unit: RTL and testbench

Load/store bus master between the core's memory stage and the naive bus; successor to the single-beat core bus wrapper.
- Parametrised bus width: 32 or 64 bits.
- Registered request/done handshake with the core.
- Holds each bus request stable until granted, so a bus conflict is retried rather than dropped.
- Optionally splits a misaligned access into two aligned bus beats.
- Performs sign/zero extension of load data.

---
 rtl/core_lsu_bus_unit_if.sv | 53 +++++
 rtl/core_lsu_bus_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_core_lsu_bus_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_bus_unit_if.sv
// Core/bus signal bundle for core_lsu_bus_unit.
// The core-side request/done handshake and the naive read/write bus share one
// interface so the unit has a single bundle port.
//   master : the LSU's view (drives o_* and the bus requests)
//   slave  : the environment's view (core plus bus responder)
interface core_lsu_bus_unit_if #(
  parameter int BUS_W = 32
);
  localparam int BUS_BYTES = BUS_W/8;

  // core side
  logic                 i_req;
  logic                 i_we;
  logic [2:0]           i_funct3;
  logic [31:0]          i_addr;
  logic [BUS_W-1:0]     i_wdata;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [BUS_W-1:0]     o_rdata;

  // naive bus, read channel
  logic                 rd_req;
  logic                 rd_gnt;
  logic [BUS_BYTES-1:0] rd_be;
  logic [31:0]          rd_addr;
  logic [BUS_W-1:0]     rd_data;

  // naive bus, write channel
  logic                 wr_req;
  logic                 wr_gnt;
  logic [BUS_BYTES-1:0] wr_be;
  logic [31:0]          wr_addr;
  logic [BUS_W-1:0]     wr_data;

  modport master (
    input  i_req, i_we, i_funct3, i_addr, i_wdata,
    output o_busy, o_done, o_err, o_rdata,
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    output i_req, i_we, i_funct3, i_addr, i_wdata,
    input  o_busy, o_done, o_err, o_rdata,
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );
endinterface

// File: rtl/core_lsu_bus_unit.sv
// Load/store bus master between the core memory stage and the naive bus.
// Accepts one access at a time from the core (i_req held until o_done),
// turns it into one or two aligned bus beats, holds each beat stable until
// granted, and returns sign/zero-extended load data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (master)    core handshake: i_req/i_we/i_funct3/i_addr/i_wdata in,
//                   o_busy/o_done/o_err/o_rdata out;
//                   read bus: rd_req/rd_be/rd_addr out, rd_gnt/rd_data in;
//                   write bus: wr_req/wr_be/wr_addr/wr_data out, wr_gnt in
// Parameters:
//   BUS_W            32 or 64
//   SPLIT_MISALIGNED 1: split accesses crossing a bus word; 0: flag them as errors
module core_lsu_bus_unit #(
  parameter int BUS_W            = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  core_lsu_bus_unit_if.master bus
);
  localparam int BB    = BUS_W/8;
  localparam int LB    = $clog2(BB);
  localparam int SPAN  = 2*BB;
  localparam int SPANW = 2*BUS_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE
  } state_t;

  state_t           r_state;
  logic             r_we;
  logic             r_split;
  logic [2:0]       r_f3;
  logic [LB-1:0]    r_off;
  logic [31:0]      r_addr1;
  logic [BB-1:0]    r_be1;
  logic [BUS_W-1:0] r_wd1;
  logic [BUS_W-1:0] r_buf0;
  logic [BUS_W-1:0] r_buf1;
  logic [BUS_W-1:0] r_rdata;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_rd_req;
  logic [BB-1:0]    r_rd_be;
  logic [31:0]      r_rd_addr;
  logic             r_wr_req;
  logic [BB-1:0]    r_wr_be;
  logic [31:0]      r_wr_addr;
  logic [BUS_W-1:0] r_wr_data;

  // ---- request decode (combinational on the core inputs, used at accept) ----
  logic [LB-1:0]    w_off;
  logic [3:0]       w_size;
  logic             w_ill;
  logic             w_mis;
  logic             w_bad;
  logic [SPAN-1:0]  w_bmask;
  logic [SPANW-1:0] w_wd2;
  logic [31:0]      w_addr0;
  logic [31:0]      w_addr1;

  assign w_off   = bus.i_addr[LB-1:0];
  assign w_size  = 4'd1 << bus.i_funct3[1:0];
  // 64-bit accesses and LWU only exist on a 64-bit bus; unsigned stores don't exist
  assign w_ill   = (bus.i_funct3 == 3'b111) ||
                   (bus.i_funct3[2] && bus.i_we) ||
                   ((BUS_W == 32) && ((bus.i_funct3 == 3'b011) || (bus.i_funct3 == 3'b110)));
  assign w_mis   = (5'(w_off) + 5'(w_size)) > 5'(BB);
  assign w_bad   = w_ill || (w_mis && !SPLIT_MISALIGNED);
  // Lane math over two bus words: low half is beat0, high half is beat1
  assign w_bmask = SPAN'((16'd1 << w_size) - 16'd1) << w_off;
  assign w_wd2   = {{BUS_W{1'b0}}, bus.i_wdata} << {w_off, 3'b000};
  assign w_addr0 = {bus.i_addr[31:LB], {LB{1'b0}}};
  assign w_addr1 = w_addr0 + 32'(BB);  // wraps past 0xFFFFFFFF

  // ---- load extraction ----
  // The half being returned this cycle comes straight from rd_data so the
  // result can be registered on the same edge that captures the beat.
  logic [SPANW-1:0] w_cat;
  logic [BUS_W-1:0] w_shift;
  logic [BUS_W-1:0] w_keep;
  logic [BUS_W-1:0] w_ld;
  logic             w_sgn;

  assign w_cat   = (r_state == S_RSP1) ? {bus.rd_data, r_buf0} : {r_buf1, bus.rd_data};
  assign w_shift = BUS_W'(w_cat >> {r_off, 3'b000});

  always_comb begin
    w_keep = '0;
    w_sgn  = 1'b0;
    for (int b = 0; b < BB; b++)
      w_keep[8*b +: 8] = (b < (1 << r_f3[1:0])) ? 8'hFF : 8'h00;
    case (r_f3[1:0])
      2'd0:    w_sgn = w_shift[7];
      2'd1:    w_sgn = w_shift[15];
      2'd2:    w_sgn = w_shift[31];
      default: w_sgn = 1'b0;  // full-width load, nothing to extend
    endcase
    w_sgn = w_sgn & ~r_f3[2];
    w_ld  = (w_shift & w_keep) | ({BUS_W{w_sgn}} & ~w_keep);
  end

  // ---- control FSM, all outputs registered ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_split   <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_addr1   <= '0;
      r_be1     <= '0;
      r_wd1     <= '0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_req  <= 1'b0;
      r_rd_be   <= '0;
      r_rd_addr <= '0;
      r_wr_req  <= 1'b0;
      r_wr_be   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.i_req) begin
          r_we    <= bus.i_we;
          r_f3    <= bus.i_funct3;
          r_off   <= w_off;
          r_split <= w_mis;
          r_addr1 <= w_addr1;
          r_be1   <= w_bmask[SPAN-1:BB];
          r_wd1   <= w_wd2[SPANW-1:BUS_W];
          r_busy  <= 1'b1;
          if (w_bad) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_REQ0;
            if (bus.i_we) begin
              r_wr_req  <= 1'b1;
              r_wr_be   <= w_bmask[BB-1:0];
              r_wr_addr <= w_addr0;
              r_wr_data <= w_wd2[BUS_W-1:0];
            end else begin
              r_rd_req  <= 1'b1;
              r_rd_be   <= w_bmask[BB-1:0];
              r_rd_addr <= w_addr0;
            end
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        // Request registers are untouched until the grant, so a conflict
        // simply repeats the same beat.
        S_REQ0, S_REQ1: begin
          if (r_we) begin
            if (bus.wr_gnt) begin
              if (r_state == S_REQ0 && r_split) begin
                r_state   <= S_REQ1;
                r_wr_be   <= r_be1;
                r_wr_addr <= r_addr1;
                r_wr_data <= r_wd1;
              end else begin
                r_state   <= S_DONE;
                r_done    <= 1'b1;
                r_wr_req  <= 1'b0;
                r_wr_be   <= '0;
                r_wr_addr <= '0;
                r_wr_data <= '0;
              end
            end
          end else if (bus.rd_gnt) begin
            r_state   <= (r_state == S_REQ0) ? S_RSP0 : S_RSP1;
            r_rd_req  <= 1'b0;
            r_rd_be   <= '0;
            r_rd_addr <= '0;
          end
        end
        S_RSP0: begin
          r_buf0 <= bus.rd_data;
          if (r_split) begin
            r_state   <= S_REQ1;
            r_rd_req  <= 1'b1;
            r_rd_be   <= r_be1;
            r_rd_addr <= r_addr1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_ld;
          end
        end
        S_RSP1: begin
          r_buf1  <= bus.rd_data;
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_rdata <= w_ld;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_err   = r_err;
  assign bus.o_rdata = r_rdata;
  assign bus.rd_req  = r_rd_req;
  assign bus.rd_be   = r_rd_be;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_req  = r_wr_req;
  assign bus.wr_be   = r_wr_be;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
endmodule

// File: tb/tb_core_lsu_bus_unit.sv
// Directed bench for core_lsu_bus_unit. Three instances share the stimulus:
// A = 32-bit split, B = 32-bit no-split, C = 64-bit split; t_sel picks which
// one sees i_req and whose outputs are observed.
module tb_core_lsu_bus_unit;
  logic        t_clk = 1'b0;
  logic        t_rst = 1'b1;
  logic [1:0]  t_sel = 2'd0;
  logic        t_req = 1'b0;
  logic        t_we = 1'b0;
  logic [2:0]  t_f3 = 3'd0;
  logic [31:0] t_addr = 32'd0;
  logic [63:0] t_wd = 64'd0;
  logic        t_rd_gnt = 1'b0;
  logic        t_wr_gnt = 1'b0;
  logic [63:0] t_rd_data = 64'd0;

  always #5 t_clk = ~t_clk;

  core_lsu_bus_unit_if #(.BUS_W(32)) ifa ();
  core_lsu_bus_unit_if #(.BUS_W(32)) ifb ();
  core_lsu_bus_unit_if #(.BUS_W(64)) ifc ();

  core_lsu_bus_unit #(.BUS_W(32), .SPLIT_MISALIGNED(1'b1)) u_a (.clk(t_clk), .rst(t_rst), .bus(ifa.master));
  core_lsu_bus_unit #(.BUS_W(32), .SPLIT_MISALIGNED(1'b0)) u_b (.clk(t_clk), .rst(t_rst), .bus(ifb.master));
  core_lsu_bus_unit #(.BUS_W(64), .SPLIT_MISALIGNED(1'b1)) u_c (.clk(t_clk), .rst(t_rst), .bus(ifc.master));

  assign ifa.i_req = t_req && (t_sel == 2'd0);
  assign ifb.i_req = t_req && (t_sel == 2'd1);
  assign ifc.i_req = t_req && (t_sel == 2'd2);
  assign ifa.i_we = t_we;  assign ifb.i_we = t_we;  assign ifc.i_we = t_we;
  assign ifa.i_funct3 = t_f3;  assign ifb.i_funct3 = t_f3;  assign ifc.i_funct3 = t_f3;
  assign ifa.i_addr = t_addr;  assign ifb.i_addr = t_addr;  assign ifc.i_addr = t_addr;
  assign ifa.i_wdata = t_wd[31:0];  assign ifb.i_wdata = t_wd[31:0];  assign ifc.i_wdata = t_wd;
  assign ifa.rd_gnt = t_rd_gnt;  assign ifb.rd_gnt = t_rd_gnt;  assign ifc.rd_gnt = t_rd_gnt;
  assign ifa.wr_gnt = t_wr_gnt;  assign ifb.wr_gnt = t_wr_gnt;  assign ifc.wr_gnt = t_wr_gnt;
  assign ifa.rd_data = t_rd_data[31:0];  assign ifb.rd_data = t_rd_data[31:0];  assign ifc.rd_data = t_rd_data;

  // observed outputs of the selected instance, zero-extended to 64 bits
  logic        ob_busy, ob_done, ob_err, ob_rd_req, ob_wr_req;
  logic [63:0] ob_rdata, ob_wr_data;
  logic [7:0]  ob_rd_be, ob_wr_be;
  logic [31:0] ob_rd_addr, ob_wr_addr;

  always_comb begin
    ob_busy = ifa.o_busy;  ob_done = ifa.o_done;  ob_err = ifa.o_err;
    ob_rdata = {32'd0, ifa.o_rdata};
    ob_rd_req = ifa.rd_req;  ob_rd_be = {4'd0, ifa.rd_be};  ob_rd_addr = ifa.rd_addr;
    ob_wr_req = ifa.wr_req;  ob_wr_be = {4'd0, ifa.wr_be};  ob_wr_addr = ifa.wr_addr;
    ob_wr_data = {32'd0, ifa.wr_data};
    if (t_sel == 2'd1) begin
      ob_busy = ifb.o_busy;  ob_done = ifb.o_done;  ob_err = ifb.o_err;
      ob_rdata = {32'd0, ifb.o_rdata};
      ob_rd_req = ifb.rd_req;  ob_rd_be = {4'd0, ifb.rd_be};  ob_rd_addr = ifb.rd_addr;
      ob_wr_req = ifb.wr_req;  ob_wr_be = {4'd0, ifb.wr_be};  ob_wr_addr = ifb.wr_addr;
      ob_wr_data = {32'd0, ifb.wr_data};
    end else if (t_sel == 2'd2) begin
      ob_busy = ifc.o_busy;  ob_done = ifc.o_done;  ob_err = ifc.o_err;
      ob_rdata = ifc.o_rdata;
      ob_rd_req = ifc.rd_req;  ob_rd_be = ifc.rd_be;  ob_rd_addr = ifc.rd_addr;
      ob_wr_req = ifc.wr_req;  ob_wr_be = ifc.wr_be;  ob_wr_addr = ifc.wr_addr;
      ob_wr_data = ifc.wr_data;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // results of the last run
  int          r_lat, r_nb, r_proto;
  logic        r_err;
  logic [63:0] r_rdata;
  logic [31:0] b_addr [2];
  logic [7:0]  b_be   [2];
  logic [63:0] b_data [2];

  // Issue one access and act as bus responder until o_done (40-cycle bound).
  // wait0 = grant-wait cycles on beat0. r_proto counts protocol breaks:
  // unstable held beats, nonzero idle bus fields, both reqs, busy wrong.
  task automatic run(input logic [1:0] sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wd,
                     input logic [63:0] rd0, input logic [63:0] rd1, input int wait0);
    int          k;
    int          wcnt;
    logic        seen;
    logic        pend;
    logic [63:0] pv;
    logic [31:0] ca;
    logic [7:0]  cb;
    logic [63:0] cd;
    t_sel = sel;  t_we = we;  t_f3 = f3;  t_addr = addr;  t_wd = wd;  t_req = 1'b1;
    r_lat = -1;  r_nb = 0;  r_proto = 0;  r_err = 1'b0;  r_rdata = 64'd0;
    for (int i = 0; i < 2; i++) begin b_addr[i] = 32'd0; b_be[i] = 8'd0; b_data[i] = 64'd0; end
    wcnt = wait0;  seen = 1'b0;  pend = 1'b0;  pv = 64'd0;  k = 0;
    @(posedge t_clk);  // accept edge, cycle c
    while (r_lat < 0 && k < 40) begin
      k++;
      @(negedge t_clk);
      t_rd_data = pend ? pv : 64'd0;
      pend = 1'b0;
      t_rd_gnt = 1'b0;  t_wr_gnt = 1'b0;
      if (!ob_busy) r_proto++;
      if (ob_rd_req && ob_wr_req) r_proto++;
      if (!ob_rd_req && (ob_rd_addr != 0 || ob_rd_be != 0)) r_proto++;
      if (!ob_wr_req && (ob_wr_addr != 0 || ob_wr_be != 0 || ob_wr_data != 0)) r_proto++;
      if (ob_done) begin
        r_lat = k;  r_err = ob_err;  r_rdata = ob_rdata;  t_req = 1'b0;
      end else if (ob_rd_req || ob_wr_req) begin
        ca = ob_rd_req ? ob_rd_addr : ob_wr_addr;
        cb = ob_rd_req ? ob_rd_be : ob_wr_be;
        cd = ob_rd_req ? 64'd0 : ob_wr_data;
        if (!seen) begin
          seen = 1'b1;
          if (r_nb < 2) begin b_addr[r_nb] = ca; b_be[r_nb] = cb; b_data[r_nb] = cd; end
        end else if (r_nb < 2 && (ca != b_addr[r_nb] || cb != b_be[r_nb] || cd != b_data[r_nb])) begin
          r_proto++;
        end
        if (wcnt > 0) wcnt--;
        else begin
          if (ob_rd_req) begin t_rd_gnt = 1'b1; pend = 1'b1; pv = (r_nb == 0) ? rd0 : rd1; end
          else t_wr_gnt = 1'b1;
          r_nb++;
          seen = 1'b0;
        end
      end
    end
    t_req = 1'b0;  t_rd_gnt = 1'b0;  t_wr_gnt = 1'b0;
    @(negedge t_clk);  // cycle after o_done: back in IDLE
    t_rd_data = 64'd0;
    if (ob_busy || ob_done) r_proto++;
  endtask

  task automatic expect_run(input string tag, input int lat, input logic err, input int nb);
    chk({tag, "_lat"},   64'(r_lat),   64'(lat));
    chk({tag, "_err"},   64'(r_err),   64'(err));
    chk({tag, "_beats"}, 64'(r_nb),    64'(nb));
    chk({tag, "_proto"}, 64'(r_proto), 64'd0);
  endtask

  int n_done;

  initial begin
    repeat (3) @(posedge t_clk);
    @(negedge t_clk);
    chk("rst_busy",  64'(ob_busy), 64'd0);
    chk("rst_done",  64'(ob_done), 64'd0);
    chk("rst_rdata", ob_rdata, 64'd0);
    chk("rst_req",   64'({ob_rd_req, ob_wr_req}), 64'd0);
    chk("rst_addr",  64'({ob_rd_addr, ob_wr_addr}), 64'd0);
    t_rst = 1'b0;
    @(negedge t_clk);

    // aligned LW
    run(2'd0, 1'b0, 3'b010, 32'h100, 64'd0, 64'h8899AABB, 64'd0, 0);
    expect_run("lw", 3, 1'b0, 1);
    chk("lw_addr", 64'(b_addr[0]), 64'h100);
    chk("lw_be",   64'(b_be[0]), 64'hF);
    chk("lw_data", r_rdata, 64'h8899AABB);

    // LB / LBU in the top lane
    run(2'd0, 1'b0, 3'b000, 32'h103, 64'd0, 64'h80000000, 64'd0, 0);
    expect_run("lb", 3, 1'b0, 1);
    chk("lb_be",   64'(b_be[0]), 64'h8);
    chk("lb_data", r_rdata, 64'hFFFFFF80);
    run(2'd0, 1'b0, 3'b100, 32'h103, 64'd0, 64'h80000000, 64'd0, 0);
    expect_run("lbu", 3, 1'b0, 1);
    chk("lbu_data", r_rdata, 64'h80);

    // split SW
    run(2'd0, 1'b1, 3'b010, 32'h102, 64'h11223344, 64'd0, 64'd0, 0);
    expect_run("sw_split", 3, 1'b0, 2);
    chk("sw_b0_addr", 64'(b_addr[0]), 64'h100);
    chk("sw_b0_be",   64'(b_be[0]), 64'hC);
    chk("sw_b0_data", b_data[0], 64'h33440000);
    chk("sw_b1_addr", 64'(b_addr[1]), 64'h104);
    chk("sw_b1_be",   64'(b_be[1]), 64'h3);
    chk("sw_b1_data", b_data[1], 64'h00001122);
    chk("sw_rdata_kept", r_rdata, 64'h80);

    // split LH, then the same at the top of the address space
    run(2'd0, 1'b0, 3'b001, 32'h103, 64'd0, 64'hAB000000, 64'h000000CD, 0);
    expect_run("lh_split", 5, 1'b0, 2);
    chk("lh_b0_be",   64'(b_be[0]), 64'h8);
    chk("lh_b1_addr", 64'(b_addr[1]), 64'h104);
    chk("lh_b1_be",   64'(b_be[1]), 64'h1);
    chk("lh_data",    r_rdata, 64'hFFFFCDAB);
    run(2'd0, 1'b0, 3'b001, 32'hFFFFFFFF, 64'd0, 64'hAB000000, 64'h000000CD, 0);
    expect_run("lh_wrap", 5, 1'b0, 2);
    chk("lh_wrap_b0_addr", 64'(b_addr[0]), 64'hFFFFFFFC);
    chk("lh_wrap_b1_addr", 64'(b_addr[1]), 64'h0);
    chk("lh_wrap_data",    r_rdata, 64'hFFFFCDAB);

    // SW with 3 cycles of grant conflict: beat held stable, 3 extra cycles
    run(2'd0, 1'b1, 3'b010, 32'h200, 64'hDEADBEEF, 64'd0, 64'd0, 3);
    expect_run("sw_wait", 5, 1'b0, 1);
    chk("sw_wait_addr", 64'(b_addr[0]), 64'h200);
    chk("sw_wait_data", b_data[0], 64'hDEADBEEF);

    // illegal on a 32-bit bus: unsigned store, LD
    run(2'd0, 1'b1, 3'b100, 32'h100, 64'd0, 64'd0, 64'd0, 0);
    expect_run("ill_sbu", 1, 1'b1, 0);
    chk("ill_rdata_kept", r_rdata, 64'hFFFFCDAB);
    run(2'd0, 1'b0, 3'b011, 32'h100, 64'd0, 64'd0, 64'd0, 0);
    expect_run("ill_ld32", 1, 1'b1, 0);

    // reset in RSP0 aborts the load without o_done
    t_sel = 2'd0;  t_we = 1'b0;  t_f3 = 3'b010;  t_addr = 32'h300;  t_req = 1'b1;
    @(posedge t_clk);
    @(negedge t_clk);           // c+1, REQ0
    chk("abort_rdreq", 64'(ob_rd_req), 64'd1);
    t_rd_gnt = 1'b1;
    @(negedge t_clk);           // c+2, RSP0
    t_rd_gnt = 1'b0;  t_rd_data = 64'h12345678;  t_rst = 1'b1;  t_req = 1'b0;
    @(negedge t_clk);
    t_rst = 1'b0;  t_rd_data = 64'd0;
    chk("abort_req",  64'({ob_rd_req, ob_wr_req}), 64'd0);
    chk("abort_busy", 64'(ob_busy), 64'd0);
    n_done = 0;
    repeat (4) begin
      if (ob_done) n_done++;
      @(negedge t_clk);
    end
    chk("abort_no_done", 64'(n_done), 64'd0);

    // no-split instance: misaligned LW is an error, no bus traffic
    run(2'd1, 1'b0, 3'b010, 32'h002, 64'd0, 64'd0, 64'd0, 0);
    expect_run("nosplit_lw", 1, 1'b1, 0);
    chk("nosplit_rdata", r_rdata, 64'd0);

    // 64-bit instance
    run(2'd2, 1'b0, 3'b011, 32'h8, 64'd0, 64'hF123456789ABCDEF, 64'd0, 0);
    expect_run("ld64", 3, 1'b0, 1);
    chk("ld64_addr", 64'(b_addr[0]), 64'h8);
    chk("ld64_be",   64'(b_be[0]), 64'hFF);
    chk("ld64_data", r_rdata, 64'hF123456789ABCDEF);
    run(2'd2, 1'b0, 3'b010, 32'hC, 64'd0, 64'h8000000100000000, 64'd0, 0);
    expect_run("lw64", 3, 1'b0, 1);
    chk("lw64_be",   64'(b_be[0]), 64'hF0);
    chk("lw64_data", r_rdata, 64'hFFFFFFFF80000001);
    run(2'd2, 1'b0, 3'b110, 32'hC, 64'd0, 64'h8000000100000000, 64'd0, 0);
    expect_run("lwu64", 3, 1'b0, 1);
    chk("lwu64_data", r_rdata, 64'h0000000080000001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
